// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle hardwired sequencer for the single-bus RISC datapath
module mc_control_unit #(
   parameter int DATA_W    = 32,
   parameter int OPCODE_W  = 5,
   parameter int CNT_W     = 32,
   parameter bit MULDIV_HS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] ir_data,
   input  logic              mem_ready, alu_done, con_out, stop, resume,
   output logic              pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, read, write,
   output logic              y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out,
   output logic              gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, inport_out, outport_in,
   output logic [3:0]        alu_op,
   output logic              alu_start, run, illegal,
   output logic [CNT_W-1:0]  instr_count
);
   typedef enum logic [5:0] {
      RST, F0, F1, F2, F3, DEC, LD1, LD2, LD3, LD4, LD5, ST4, ST5, A1, A2, I2, WB,
      M1, M2, M3, M4, M5, M6, N1, B1, B2, B3, B4, JR, J1, J2, IO_IN, IO_OUT, MFHI, MFLO, HALT
   } state_t;
   typedef struct packed {
      logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, read, write;
      logic y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out;
      logic gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, inport_out, outport_in, alu_start;
   } strb_t;
   state_t state_q, state_d;
   strb_t strb_q, strb_d;
   logic [3:0] alu_op_q, alu_op_d, op_sel;
   logic run_q, run_d, ill_q, ill_d, fin, pc_in_r;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OPCODE_W-1:0] opc;
   logic ir_unused;
   assign opc = ir_data[DATA_W-1 -: OPCODE_W];
   assign ir_unused = ^ir_data[DATA_W-OPCODE_W-1:0];
   // ALU function selected by the opcode held in IR
   always_comb begin
      case (opc)
         OPCODE_W'(3), OPCODE_W'(11): op_sel = 4'd2;
         OPCODE_W'(4):                op_sel = 4'd3;
         OPCODE_W'(5):                op_sel = 4'd4;
         OPCODE_W'(6):                op_sel = 4'd5;
         OPCODE_W'(7):                op_sel = 4'd6;
         OPCODE_W'(8):                op_sel = 4'd7;
         OPCODE_W'(10), OPCODE_W'(13): op_sel = 4'd1;
         OPCODE_W'(14):               op_sel = 4'd8;
         OPCODE_W'(15):               op_sel = 4'd9;
         OPCODE_W'(16):               op_sel = 4'd10;
         OPCODE_W'(17):               op_sel = 4'd11;
         default:                     op_sel = 4'd0;
      endcase
   end
   // next state, illegal flag and retire counter; fin marks an instruction boundary
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ill_d = ill_q;
      fin = 1'b0;
      case (state_q)
         RST: state_d = F0;
         F0:  state_d = F1;
         F1:  state_d = F2;
         F2:  state_d = mem_ready ? F3 : F2;
         F3:  state_d = DEC;
         DEC: begin
            fin = opc == OPCODE_W'(25);
            ill_d = ill_q | (opc > OPCODE_W'(26));
            state_d = opc <= OPCODE_W'(2)  ? LD1 :
                      opc <= OPCODE_W'(13) ? A1 :
                      opc <= OPCODE_W'(15) ? M1 :
                      opc <= OPCODE_W'(17) ? N1 :
                      opc == OPCODE_W'(18) ? B1 :
                      opc == OPCODE_W'(19) ? JR :
                      opc == OPCODE_W'(20) ? J1 :
                      opc == OPCODE_W'(21) ? IO_IN :
                      opc == OPCODE_W'(22) ? IO_OUT :
                      opc == OPCODE_W'(23) ? MFHI :
                      opc == OPCODE_W'(24) ? MFLO : HALT;
         end
         LD1: state_d = LD2;
         LD2: state_d = opc == OPCODE_W'(1) ? WB : LD3;
         LD3: state_d = opc == OPCODE_W'(2) ? ST4 : LD4;
         LD4: state_d = mem_ready ? LD5 : LD4;
         ST4: state_d = ST5;
         ST5: fin = mem_ready;
         A1:  state_d = opc >= OPCODE_W'(11) ? I2 : A2;
         A2, I2, N1: state_d = WB;
         M1:  state_d = M2;
         M2:  state_d = MULDIV_HS ? M3 : M4;
         M3:  state_d = alu_done ? M4 : M3;
         M4:  state_d = M5;
         M5:  state_d = M6;
         B1:  state_d = B2;
         B2:  state_d = B3;
         B3:  state_d = B4;
         J1:  state_d = J2;
         HALT: begin
            state_d = resume ? F0 : HALT;
            ill_d = resume ? 1'b0 : ill_q;
         end
         default: fin = 1'b1;
      endcase
      if (fin) begin
         state_d = stop ? HALT : F0;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end
   // strobes decoded from the state being entered so the outputs come straight from flops
   always_comb begin
      strb_d.pc_out     = state_d inside {F0, B2, J1};
      strb_d.pc_in      = state_d inside {F1, JR, J2};
      strb_d.inc_pc     = state_d == F0;
      strb_d.mar_in     = state_d inside {F0, LD3};
      strb_d.mdr_in     = state_d inside {F2, LD4, ST4};
      strb_d.mdr_out    = state_d inside {F3, LD5};
      strb_d.ir_in      = state_d == F3;
      strb_d.read       = state_d inside {F2, LD4};
      strb_d.write      = state_d == ST5;
      strb_d.y_in       = state_d inside {LD1, A1, M1, B2};
      strb_d.z_in       = state_d inside {F0, LD2, A2, I2, M4, N1, B3};
      strb_d.z_low_out  = state_d inside {F1, LD3, WB, M5, B4};
      strb_d.z_high_out = state_d == M6;
      strb_d.hi_in      = state_d == M6;
      strb_d.hi_out     = state_d == MFHI;
      strb_d.lo_in      = state_d == M5;
      strb_d.lo_out     = state_d == MFLO;
      strb_d.gra        = state_d inside {LD5, WB, ST4, M1, B1, JR, J2, IO_IN, IO_OUT, MFHI, MFLO};
      strb_d.grb        = state_d inside {LD1, A1, M2, M3, M4, N1, J1};
      strb_d.grc        = state_d == A2;
      strb_d.r_in       = state_d inside {LD5, WB, J1, IO_IN, MFHI, MFLO};
      strb_d.r_out      = state_d inside {ST4, A1, A2, M1, M2, M3, M4, N1, B1, JR, J2, IO_OUT};
      strb_d.ba_out     = state_d == LD1;
      strb_d.c_out      = state_d inside {LD2, I2, B3};
      strb_d.con_in     = state_d == B1;
      strb_d.inport_out = state_d == IO_IN;
      strb_d.outport_in = state_d == IO_OUT;
      strb_d.alu_start  = state_d == M2;
      alu_op_d = state_d inside {F0, LD2, B3} ? 4'd2 : state_d inside {A2, I2, M2, M3, M4, N1} ? op_sel : 4'd0;
      run_d = !(state_d inside {RST, HALT});
   end
   // state and registered outputs; reset wins over every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RST;
         strb_q <= '0;
         alu_op_q <= '0;
         run_q <= 1'b0;
         ill_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         strb_q <= strb_d;
         alu_op_q <= alu_op_d;
         run_q <= run_d;
         ill_q <= ill_d;
         cnt_q <= cnt_d;
      end
   end
   assign {pc_out, pc_in_r, inc_pc, mar_in, mdr_in, mdr_out, ir_in, read, write,
           y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out,
           gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, inport_out, outport_in, alu_start} = strb_q;
   assign pc_in = pc_in_r | (state_q == B4 && con_out);
   assign alu_op = alu_op_q;
   assign run = run_q;
   assign illegal = ill_q;
   assign instr_count = cnt_q;
endmodule
